// File: rtl/flash_arb_pkg.sv
// Shared types and default widths for the flash read arbiter.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam int FL_ADDR_W = 21;
    localparam int FL_DATA_W = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches last+1, last+2, ... modulo N_REQ
// and returns the first active request as a one-hot vector and an index.
module rr_pick #(
    parameter int N_REQ = 5,
    parameter int IDX_W = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] pos;
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            pos = IDX_W'((int'(last) + i) % N_REQ);
            if (!found && req[pos]) begin
                found      = 1'b1;
                win[pos]   = 1'b1;
                win_idx    = pos;
            end
        end
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one flash read port among N_REQ requesters.
// Optional ack watchdog enabled by defining FLASH_ARB_TIMEOUT_EN.
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int N_REQ   = 5,
    parameter int ADDR_W  = FL_ADDR_W,
    parameter int DATA_W  = FL_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*ADDR_W-1:0]   i_addr,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [N_REQ-1:0]          o_done,
    output logic [N_REQ-1:0]          o_err,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_stb,
    output logic [ADDR_W-1:0]         o_addr,
    input  logic                      i_ack,
    input  logic [DATA_W-1:0]         i_data
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;

    if (N_REQ < 2 || TIMEOUT < 1) begin : g_param_check
        $error("flash_read_arbiter: N_REQ must be >= 2 and TIMEOUT >= 1");
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] owner;
    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             timed_out;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (i_req),
        .last    (last),
        .win     (pick_oh),
        .win_idx (pick_idx)
    );

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;

    // Fires on the last permitted WAIT cycle; an ack in that same cycle still wins.
    assign timed_out = (state == ST_WAIT) && !i_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt <= '0;
        end else if (state != ST_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err <= '0;
        end else begin
            o_err <= timed_out ? o_gnt : '0;
        end
    end
`else
    assign timed_out = 1'b0;
    assign o_err     = '0;
`endif

    // o_addr is left untouched after completion so it stays stable past the ack.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            last   <= IDX_W'(N_REQ - 1);
            owner  <= '0;
            o_gnt  <= '0;
            o_done <= '0;
            o_stb  <= 1'b0;
            o_addr <= '0;
            o_data <= '0;
        end else begin
            o_done <= '0;
            o_stb  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|i_req) begin
                        owner  <= pick_idx;
                        o_gnt  <= pick_oh;
                        o_addr <= i_addr[pick_idx*ADDR_W +: ADDR_W];
                        o_stb  <= 1'b1;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_ack) begin
                        o_data <= i_data;
                        o_done <= o_gnt;
                        o_gnt  <= '0;
                        last   <= owner;
                        state  <= ST_IDLE;
                    end else if (timed_out) begin
                        o_data <= '0;
                        o_done <= o_gnt;
                        o_gnt  <= '0;
                        last   <= owner;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed self-checking bench for flash_read_arbiter (5 requesters).
// The watchdog section runs only when FLASH_ARB_TIMEOUT_EN is defined.
module tb_flash_read_arbiter;

    localparam int N_REQ   = 5;
    localparam int ADDR_W  = 21;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                    i_clk;
    logic                    i_rst;
    logic [N_REQ-1:0]        i_req;
    logic [N_REQ*ADDR_W-1:0] i_addr;
    logic [N_REQ-1:0]        o_gnt;
    logic [N_REQ-1:0]        o_done;
    logic [N_REQ-1:0]        o_err;
    logic [DATA_W-1:0]       o_data;
    logic                    o_stb;
    logic [ADDR_W-1:0]       o_addr;
    logic                    i_ack;
    logic [DATA_W-1:0]       i_data;

    logic [ADDR_W-1:0] addr_tab [N_REQ];
    logic [N_REQ-1:0]  done_acc;
    int                checks;
    int                errors;

    flash_read_arbiter #(
        .N_REQ   (N_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_req  (i_req),
        .i_addr (i_addr),
        .o_gnt  (o_gnt),
        .o_done (o_done),
        .o_err  (o_err),
        .o_data (o_data),
        .o_stb  (o_stb),
        .o_addr (o_addr),
        .i_ack  (i_ack),
        .i_data (i_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] time limit");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"},  64'(o_gnt),  64'd0);
        checkOutput({tag, "_done"}, 64'(o_done), 64'd0);
        checkOutput({tag, "_err"},  64'(o_err),  64'd0);
        checkOutput({tag, "_stb"},  64'(o_stb),  64'd0);
        checkOutput({tag, "_addr"}, 64'(o_addr), 64'd0);
        checkOutput({tag, "_data"}, 64'(o_data), 64'd0);
    endtask

    // Starts in an IDLE cycle with requests applied; ends on the done cycle.
    task automatic applyStimulus(input int idx, input logic [DATA_W-1:0] rdata);
        logic [N_REQ-1:0] exp_oh;
        exp_oh = N_REQ'(1) << idx;
        tick();
        checkOutput("issue_gnt",  64'(o_gnt),  64'(exp_oh));
        checkOutput("issue_stb",  64'(o_stb),  64'd1);
        checkOutput("issue_addr", 64'(o_addr), 64'(addr_tab[idx]));
        tick();
        checkOutput("wait_stb", 64'(o_stb), 64'd0);
        i_ack  = 1'b1;
        i_data = rdata;
        tick();
        i_ack  = 1'b0;
        i_data = '0;
        checkOutput("done",     64'(o_done), 64'(exp_oh));
        checkOutput("done_dat", 64'(o_data), 64'(rdata));
        checkOutput("done_gnt", 64'(o_gnt),  64'd0);
        checkOutput("done_err", 64'(o_err),  64'd0);
        done_acc = done_acc | o_done;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        done_acc = '0;
        addr_tab[0] = 21'h000010;
        addr_tab[1] = 21'h001234;
        addr_tab[2] = 21'h0ABCDE;
        addr_tab[3] = 21'h1FFFFF;
        addr_tab[4] = 21'h155555;
        for (int k = 0; k < N_REQ; k++) i_addr[k*ADDR_W +: ADDR_W] = addr_tab[k];
        i_rst  = 1'b1;
        i_req  = '0;
        i_ack  = 1'b0;
        i_data = '0;

        tick();
        tick();
        checkAllZero("reset");
        i_rst = 1'b0;

        // Single request, ack in cycle 3.
        i_req = 5'b00001;
        tick();
        checkOutput("single_stb",  64'(o_stb),  64'd1);
        checkOutput("single_addr", 64'(o_addr), 64'h10);
        checkOutput("single_gnt",  64'(o_gnt),  64'b00001);
        tick();
        checkOutput("single_stb2", 64'(o_stb), 64'd0);
        tick();
        checkOutput("single_nodone", 64'(o_done), 64'd0);
        i_ack  = 1'b1;
        i_data = 32'hDEADBEEF;
        tick();
        i_ack  = 1'b0;
        i_data = '0;
        i_req  = '0;
        checkOutput("single_done", 64'(o_done), 64'b00001);
        checkOutput("single_data", 64'(o_data), 64'hDEADBEEF);
        checkOutput("single_addr_hold", 64'(o_addr), 64'h10);
        tick();
        checkOutput("single_pulse", 64'(o_done), 64'd0);
        checkOutput("single_hold",  64'(o_data), 64'hDEADBEEF);

        // Fairness from reset: 0,1,2,3,4,0.
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_req = 5'b11111;
        done_acc = '0;
        for (int k = 0; k < N_REQ; k++) applyStimulus(k, 32'h1000_0000 + 32'(k));
        checkOutput("fair_each_once", 64'(done_acc), 64'b11111);
        applyStimulus(0, 32'hA5A5_0000);

        // Skip idle requesters.
        i_req = 5'b10100;
        applyStimulus(2, 32'h2222_2222);
        applyStimulus(4, 32'h4444_4444);
        applyStimulus(2, 32'h2222_3333);

        // Spurious ack in IDLE and ISSUE.
        i_req = '0;
        i_ack = 1'b1;
        i_data = 32'hBAD0BAD0;
        tick();
        checkOutput("spur_idle1", 64'(o_done), 64'd0);
        tick();
        checkOutput("spur_idle2", 64'(o_done), 64'd0);
        i_req = 5'b00010;
        tick();
        checkOutput("spur_issue_stb", 64'(o_stb), 64'd1);
        checkOutput("spur_issue_gnt", 64'(o_gnt), 64'b00010);
        tick();
        i_ack = 1'b0;
        checkOutput("spur_wait1", 64'(o_done), 64'd0);
        tick();
        checkOutput("spur_wait2", 64'(o_done), 64'd0);
        checkOutput("spur_gnt",   64'(o_gnt),  64'b00010);
        i_ack  = 1'b1;
        i_data = 32'h0BAD_F00D;
        tick();
        i_ack  = 1'b0;
        i_data = '0;
        checkOutput("spur_done", 64'(o_done), 64'b00010);
        checkOutput("spur_data", 64'(o_data), 64'h0BADF00D);

        // Reset two cycles after stb; pointer was at 1 so requester 2 wins first.
        i_req = 5'b10101;
        tick();
        checkOutput("rst_pre_gnt", 64'(o_gnt), 64'b00100);
        tick();
        tick();
        i_rst = 1'b1;
        #1;
        checkAllZero("rst_mid");
        tick();
        i_rst = 1'b0;
        applyStimulus(0, 32'h0000_C0DE);

`ifdef FLASH_ARB_TIMEOUT_EN
        // Watchdog: no ack for requester 1, then requester 2 is granted.
        i_req = 5'b00110;
        tick();
        checkOutput("to_gnt", 64'(o_gnt), 64'b00010);
        for (int w = 0; w < TIMEOUT; w++) begin
            tick();
            checkOutput("to_wait_done", 64'(o_done), 64'd0);
        end
        tick();
        checkOutput("to_done", 64'(o_done), 64'b00010);
        checkOutput("to_err",  64'(o_err),  64'b00010);
        checkOutput("to_data", 64'(o_data), 64'd0);
        i_req = 5'b00100;
        applyStimulus(2, 32'h7777_7777);
`endif

        checkOutput("final_err", 64'(o_err), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
